// File: rtl/mem_arbiter.sv
// Purpose : arbitrates one single-ported RAM between icache fetches and dcache loads/stores.
// Latency : a request seen in cycle N drives the RAM enables in cycle N+1; completion is the ACCESS cycle.
// Backpres: a requester stalls (wait=1) until its ACCESS cycle; the non-granted side always sees wait=1.
//
// Ports:
//   CLK, RST                   clock; synchronous active-high reset
//   iREN, iaddr                icache read request and word address
//   iwait, iload               icache stall (0 only on the completing cycle) and read data
//   dREN, dWEN, daddr, dstore  dcache read/write request, word address and write data
//   dwait, dload               dcache stall (0 only on the completing cycle) and read data
//   ramREN, ramWEN             RAM read/write enables
//   ramaddr, ramstore          RAM address and write data
//   ramload, ramstate          RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   merr                       sticky error flag, cleared only by RST
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  // RAM status encoding
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       d_req;
  logic       ram_access;

  assign d_req      = dREN | dWEN;
  assign ram_access = (ramstate == RS_ACCESS);

  // Read data is a straight pass-through; the waits qualify it.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
      merr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == ERR) begin
        merr <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'd0;
    ramstore  = 32'd0;

    case (state)
      IDLE: begin
        // dcache wins ties unless icache has already been passed over STARVE_MAX times
        if (d_req && !(iREN && (cnt == CNT_MAX))) begin
          state_nxt = DGNT;
        end else if (iREN) begin
          state_nxt = IGNT;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;   // dREN together with dWEN is a write
        if (ramstate == RS_ERROR) begin
          state_nxt = ERR;
        end else if (!d_req) begin
          // requester withdrew: abandon without completion, starvation count kept
          state_nxt = IDLE;
        end else if (ram_access) begin
          dwait     = 1'b0;
          state_nxt = IDLE;
          if (!iREN) begin
            cnt_nxt = 4'd0;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (ramstate == RS_ERROR) begin
          state_nxt = ERR;
        end else if (!iREN) begin
          state_nxt = IDLE;
        end else if (ram_access) begin
          iwait     = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end

      default: begin
        // ERR: parked with everything quiet until reset
        state_nxt = ERR;
      end
    endcase

    // Reset drops the RAM enables in the same cycle and suppresses any completion.
    if (RST) begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter.
// Latency : inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
// Backpres: the bench plays the RAM, driving ramstate/ramload by hand each cycle.
module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        merr;

  int total;
  int bad;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .merr     (merr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    logic exp_d;
    int   g;
    total    = 0;
    bad      = 0;
    RST      = 1'b1;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'd0;
    dstore   = 32'd0;
    ramload  = 32'hA5A5_A5A5;
    ramstate = RS_FREE;

    // ---- reset state
    nxt();
    nxt();
    #1;
    chk("rst_iwait",    32'(iwait),  32'd1);
    chk("rst_dwait",    32'(dwait),  32'd1);
    chk("rst_ramREN",   32'(ramREN), 32'd0);
    chk("rst_ramWEN",   32'(ramWEN), 32'd0);
    chk("rst_ramaddr",  ramaddr,     32'd0);
    chk("rst_ramstore", ramstore,    32'd0);
    chk("rst_merr",     32'(merr),   32'd0);
    chk("rst_iload",    iload,       32'hA5A5_A5A5);
    chk("rst_dload",    dload,       32'hA5A5_A5A5);
    RST = 1'b0;

    // ---- icache fetch: BUSY two cycles, then ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY;
    #1;
    chk("t1_c0_ramREN", 32'(ramREN), 32'd0);
    chk("t1_c0_iwait",  32'(iwait),  32'd1);
    nxt(); #1;
    chk("t1_c1_ramREN",  32'(ramREN), 32'd1);
    chk("t1_c1_ramaddr", ramaddr,     32'h40);
    chk("t1_c1_iwait",   32'(iwait),  32'd1);
    nxt(); #1;
    chk("t1_c2_iwait",   32'(iwait),  32'd1);
    nxt();
    ramstate = RS_ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    chk("t1_c3_iwait",  32'(iwait),  32'd0);
    chk("t1_c3_iload",  iload,       32'hDEAD_BEEF);
    chk("t1_c3_dwait",  32'(dwait),  32'd1);
    chk("t1_c3_ramREN", 32'(ramREN), 32'd1);
    nxt();
    iREN = 1'b0; ramstate = RS_FREE;
    #1;
    chk("t1_c4_ramREN", 32'(ramREN), 32'd0);
    chk("t1_c4_iwait",  32'(iwait),  32'd1);

    // ---- simultaneous icache read and dcache write: dcache first
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    #1;
    chk("t2_idle_ramWEN", 32'(ramWEN), 32'd0);
    nxt();
    ramstate = RS_ACCESS;
    #1;
    chk("t2_d_ramWEN",   32'(ramWEN), 32'd1);
    chk("t2_d_ramREN",   32'(ramREN), 32'd0);
    chk("t2_d_ramaddr",  ramaddr,     32'h80);
    chk("t2_d_ramstore", ramstore,    32'h1234);
    chk("t2_d_dwait",    32'(dwait),  32'd0);
    chk("t2_d_iwait",    32'(iwait),  32'd1);
    nxt();
    dWEN = 1'b0; ramstate = RS_FREE;
    #1;
    chk("t2_gap_ramREN", 32'(ramREN), 32'd0);
    chk("t2_gap_ramWEN", 32'(ramWEN), 32'd0);
    chk("t2_gap_iwait",  32'(iwait),  32'd1);
    nxt();
    ramstate = RS_ACCESS;
    #1;
    chk("t2_i_ramREN",   32'(ramREN), 32'd1);
    chk("t2_i_ramaddr",  ramaddr,     32'h44);
    chk("t2_i_ramstore", ramstore,    32'd0);
    chk("t2_i_iwait",    32'(iwait),  32'd0);
    chk("t2_i_dwait",    32'(dwait),  32'd1);
    nxt();
    iREN = 1'b0; ramstate = RS_FREE;

    // ---- both held, RAM always ready: four dcache grants then one icache grant
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80; ramstate = RS_ACCESS;
    g = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk($sformatf("t3_c%0d_idle_dwait", c), 32'(dwait), 32'd1);
        chk($sformatf("t3_c%0d_idle_iwait", c), 32'(iwait), 32'd1);
      end else begin
        exp_d = ((g % 5) != 4);
        chk($sformatf("t3_g%0d_dwait", g),   32'(dwait), 32'(!exp_d));
        chk($sformatf("t3_g%0d_iwait", g),   32'(iwait), 32'(exp_d));
        chk($sformatf("t3_g%0d_ramaddr", g), ramaddr, exp_d ? 32'h80 : 32'h44);
        g++;
      end
      nxt();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
    #1;
    chk("t3_end_ramREN", 32'(ramREN), 32'd0);

    // ---- dcache read withdrawn while RAM busy: abort
    dREN = 1'b1; daddr = 32'h88; ramstate = RS_BUSY;
    nxt(); #1;
    chk("t4_grant_ramREN", 32'(ramREN), 32'd1);
    chk("t4_grant_dwait",  32'(dwait),  32'd1);
    dREN = 1'b0;
    #1;
    chk("t4_drop_ramREN", 32'(ramREN), 32'd0);
    chk("t4_drop_dwait",  32'(dwait),  32'd1);
    nxt(); #1;
    chk("t4_idle_ramREN", 32'(ramREN), 32'd0);
    chk("t4_idle_dwait",  32'(dwait),  32'd1);
    iREN = 1'b1; iaddr = 32'h4C;
    nxt(); #1;
    chk("t4_regrant_ramREN",  32'(ramREN), 32'd1);
    chk("t4_regrant_ramaddr", ramaddr,     32'h4C);
    iREN = 1'b0;
    nxt();

    // ---- RAM error during a dcache grant
    dREN = 1'b1; daddr = 32'h90; ramstate = RS_BUSY;
    nxt();
    ramstate = RS_ERROR;
    #1;
    chk("t5_pre_merr",  32'(merr),  32'd0);
    chk("t5_pre_dwait", 32'(dwait), 32'd1);
    nxt();
    ramstate = RS_ACCESS;
    #1;
    chk("t5_err_merr",   32'(merr),   32'd1);
    chk("t5_err_ramREN", 32'(ramREN), 32'd0);
    chk("t5_err_dwait",  32'(dwait),  32'd1);
    chk("t5_err_iwait",  32'(iwait),  32'd1);
    nxt(); #1;
    chk("t5_hold_merr",   32'(merr),   32'd1);
    chk("t5_hold_ramREN", 32'(ramREN), 32'd0);
    chk("t5_hold_dwait",  32'(dwait),  32'd1);
    RST = 1'b1; dREN = 1'b0; ramstate = RS_FREE;
    nxt();
    RST = 1'b0;
    #1;
    chk("t5_rst_merr",   32'(merr),   32'd0);
    chk("t5_rst_ramREN", 32'(ramREN), 32'd0);
    dREN = 1'b1; daddr = 32'h94;
    nxt(); #1;
    chk("t5_alive_ramREN",  32'(ramREN), 32'd1);
    chk("t5_alive_ramaddr", ramaddr,     32'h94);
    dREN = 1'b0;
    nxt();

    // ---- reset pulse during an icache grant
    iREN = 1'b1; iaddr = 32'h48; ramstate = RS_BUSY;
    nxt(); #1;
    chk("t6_grant_ramREN", 32'(ramREN), 32'd1);
    RST = 1'b1;
    #1;
    chk("t6_rst_ramREN", 32'(ramREN), 32'd0);
    chk("t6_rst_iwait",  32'(iwait),  32'd1);
    nxt();
    RST = 1'b0; iREN = 1'b0;
    #1;
    chk("t6_after_ramREN", 32'(ramREN), 32'd0);
    chk("t6_after_iwait",  32'(iwait),  32'd1);
    chk("t6_after_merr",   32'(merr),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
